// File: rtl/dmem_bus_bridge_pkg.sv
// Shared definitions for the MEM-stage data bus bridge: FSM encoding, abort read data
// and the timeout counter width helper.
package dmem_bus_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  localparam logic [31:0] DMEM_ERR_RDATA = 32'hDEAD_BEEF;

  // Counter is wide enough to hold the limit, but never narrower than 8 or wider than 16 bits.
  function automatic int dmem_cnt_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    if (w < 8) w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/dmem_bus_bridge_if.sv
// Ready-handshaked data bus between the bridge (master) and the memory system (slave).
// Handshake: bus_req/bus_we/bus_addr/bus_wdata are held stable until a cycle with
// bus_req & bus_ready, which completes the access; bus_rdata is valid in that cycle for reads.
interface dmem_bus_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ready;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/dmem_bus_bridge_timeout_cnt.sv
// BUSY-cycle watchdog for the bridge; hit_o fires on the increment that reaches LIMIT.
module dmem_timeout_cnt #(
  parameter int CNT_W = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic hit_o
);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign hit_o = inc_i & (cnt_q == CNT_W'(LIMIT - 1));
endmodule

// File: rtl/dmem_bus_bridge.sv
// Multi-cycle bridge from the MEM stage to a ready-handshaked data bus, stalling the pipeline
// while an access is outstanding. Optional BUSY timeout/abort under `define DMEM_TIMEOUT_EN.
module dmem_bus_bridge
  import dmem_bus_bridge_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_stall,
  output logic              bus_err,
  output dmem_state_e       dbg_state_o,
  dmem_bus_bridge_if.master bus
);

  dmem_state_e       state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              mem_req;
  logic              unused_addr_lsb;

  assign mem_req         = mem_ren | mem_wen;
  assign unused_addr_lsb = ^mem_addr[1:0];

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = dmem_cnt_width(TIMEOUT_CYC);
  logic cnt_clr, cnt_inc, cnt_hit;
  logic err_q, err_d;

  assign cnt_clr = (state_q == IDLE) & mem_req;
  assign cnt_inc = (state_q == BUSY) & ~bus.bus_ready;

  dmem_timeout_cnt #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .hit_o (cnt_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign bus_err = err_q;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      din_q   <= din_d;
    end
  end

  // Request inputs are only sampled in IDLE; bus-side registers stay frozen through BUSY.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    din_d   = din_q;
`ifdef DMEM_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = mem_wen;
          addr_d  = {mem_addr[ADDR_W-1:2], 2'b00};
          wdata_d = mem_dout;
        end
      end
      BUSY: begin
        if (bus.bus_ready) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!we_q) din_d = bus.bus_rdata;
        end
`ifdef DMEM_TIMEOUT_EN
        else if (cnt_hit) begin
          state_d = DONE;
          req_d   = 1'b0;
          err_d   = 1'b1;
          if (!we_q) din_d = DATA_W'(DMEM_ERR_RDATA);
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_stall     = ((state_q == IDLE) & mem_req) | (state_q == BUSY);
  assign mem_din       = din_q;
  assign dbg_state_o   = state_q;
  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed bench for dmem_bus_bridge: one task per scenario with inline checks.
// The timeout scenario runs when DMEM_TIMEOUT_EN is defined, the indefinite-wait one otherwise.
module tb_dmem_bus_bridge;
  import dmem_bus_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_dout;
  logic [31:0] mem_din;
  logic        mem_stall, bus_err;
  dmem_state_e dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;
  int txn_cnt      = 0;
  logic [31:0] exp_q[$];

  dmem_bus_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  dmem_bus_bridge #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_ren     (mem_ren),
    .mem_wen     (mem_wen),
    .mem_addr    (mem_addr),
    .mem_dout    (mem_dout),
    .mem_din     (mem_din),
    .mem_stall   (mem_stall),
    .bus_err     (bus_err),
    .dbg_state_o (dbg_state),
    .bus         (bus_if.master)
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Completed bus transactions
  always @(posedge clk) begin
    if (rst_n && bus_if.bus_req && bus_if.bus_ready) txn_cnt <= txn_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_dout = '0;
    bus_if.bus_ready = 1'b0; bus_if.bus_rdata = '0;
    #2;
    tests_run++;
    if (dbg_state !== IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
    tests_run++;
    if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata} !== 66'd0) begin
      tests_failed++; $display("FAIL reset_bus: req=%b we=%b addr=%h wdata=%h want all 0",
        bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata);
    end
    tests_run++;
    if ({mem_din, mem_stall, bus_err} !== 34'd0) begin
      tests_failed++; $display("FAIL reset_mem: din=%h stall=%b err=%b want 0", mem_din, mem_stall, bus_err);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_spurious_ready();
    int base;
    base = txn_cnt;
    bus_if.bus_ready = 1'b1;
    #1;
    tests_run++;
    if (mem_stall !== 1'b0) begin tests_failed++; $display("FAIL spurious_stall: got %b want 0", mem_stall); end
    tick();
    tests_run++;
    if (dbg_state !== IDLE || bus_if.bus_req !== 1'b0 || txn_cnt != base) begin
      tests_failed++; $display("FAIL spurious_state: state=%0d req=%b txns=%0d want IDLE 0 %0d",
        dbg_state, bus_if.bus_req, txn_cnt, base);
    end
    bus_if.bus_ready = 1'b0;
  endtask

  task automatic test_read_zero_wait();
    int stalls = 0;
    mem_ren = 1'b1; mem_addr = 32'h0000_0013;
    bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 32'h1234_5678;
    exp_q.push_back(32'h1234_5678);
    #1; stalls += int'(mem_stall);
    tick(); stalls += int'(mem_stall);
    tests_run++;
    if (dbg_state !== BUSY || bus_if.bus_req !== 1'b1 || bus_if.bus_we !== 1'b0 || bus_if.bus_addr !== 32'h10) begin
      tests_failed++; $display("FAIL read_busy: state=%0d req=%b we=%b addr=%h want BUSY 1 0 00000010",
        dbg_state, bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr);
    end
    tick(); stalls += int'(mem_stall);
    tests_run++;
    if (dbg_state !== DONE || bus_if.bus_req !== 1'b0) begin
      tests_failed++; $display("FAIL read_done: state=%0d req=%b want DONE 0", dbg_state, bus_if.bus_req);
    end
    tests_run++;
    if (mem_din !== exp_q[0]) begin tests_failed++; $display("FAIL read_data: got %h want %h", mem_din, exp_q[0]); end
    void'(exp_q.pop_front());
    tests_run++;
    if (stalls != 2) begin tests_failed++; $display("FAIL read_stall_cycles: got %0d want 2", stalls); end
    mem_ren = 1'b0; bus_if.bus_ready = 1'b0;
    tick();
  endtask

  task automatic test_write_wait();
    int stalls = 0;
    int bad = 0;
    mem_wen = 1'b1; mem_addr = 32'h20; mem_dout = 32'hCAFE_F00D; bus_if.bus_ready = 1'b0;
    #1; stalls += int'(mem_stall);
    for (int i = 0; i < 4; i++) begin
      tick(); stalls += int'(mem_stall);
      mem_dout = 32'h0; mem_addr = 32'hFFFF_FFFC;
      if (dbg_state !== BUSY || bus_if.bus_req !== 1'b1 || bus_if.bus_we !== 1'b1 ||
          bus_if.bus_addr !== 32'h20 || bus_if.bus_wdata !== 32'hCAFE_F00D) bad++;
      if (i == 3) bus_if.bus_ready = 1'b1;
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL write_stable: %0d unstable BUSY cycles, want 0", bad); end
    tick(); stalls += int'(mem_stall);
    tests_run++;
    if (dbg_state !== DONE || mem_din !== 32'h1234_5678) begin
      tests_failed++; $display("FAIL write_done: state=%0d din=%h want DONE 12345678", dbg_state, mem_din);
    end
    tests_run++;
    if (stalls != 5) begin tests_failed++; $display("FAIL write_stall_cycles: got %0d want 5", stalls); end
    mem_wen = 1'b0; bus_if.bus_ready = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int base;
    base = txn_cnt;
    mem_ren = 1'b1; mem_addr = 32'h40; bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 32'hA5A5_0040;
    exp_q.push_back(32'hA5A5_0040);
    tick(); tick();
    mem_ren = 1'b0; mem_wen = 1'b1; mem_addr = 32'h44; mem_dout = 32'h0BAD_CAFE;
    #1;
    tests_run++;
    if (dbg_state !== DONE || mem_stall !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_done: state=%0d stall=%b want DONE 0", dbg_state, mem_stall);
    end
    tick();
    tests_run++;
    if (dbg_state !== IDLE || mem_stall !== 1'b1 || bus_if.bus_req !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_idle: state=%0d stall=%b req=%b want IDLE 1 0", dbg_state, mem_stall, bus_if.bus_req);
    end
    tick();
    tests_run++;
    if (bus_if.bus_req !== 1'b1 || bus_if.bus_we !== 1'b1 || bus_if.bus_addr !== 32'h44) begin
      tests_failed++; $display("FAIL b2b_second_req: req=%b we=%b addr=%h want 1 1 00000044",
        bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr);
    end
    tick();
    mem_wen = 1'b0; bus_if.bus_ready = 1'b0;
    tests_run++;
    if (txn_cnt - base != 2) begin tests_failed++; $display("FAIL b2b_txns: got %0d want 2", txn_cnt - base); end
    tests_run++;
    if (mem_din !== exp_q[0]) begin tests_failed++; $display("FAIL b2b_data: got %h want %h", mem_din, exp_q[0]); end
    void'(exp_q.pop_front());
    tick();
  endtask

  task automatic test_ren_wen_both();
    mem_ren = 1'b1; mem_wen = 1'b1; mem_addr = 32'h104; mem_dout = 32'h5555_AAAA;
    bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 32'hFFFF_0000;
    $display("[TB] note: mem_ren and mem_wen both high (illegal upstream), expecting a write");
    tick();
    tests_run++;
    if (bus_if.bus_we !== 1'b1 || bus_if.bus_wdata !== 32'h5555_AAAA) begin
      tests_failed++; $display("FAIL both_is_write: we=%b wdata=%h want 1 5555aaaa", bus_if.bus_we, bus_if.bus_wdata);
    end
    tick();
    tests_run++;
    if (mem_din !== 32'hA5A5_0040) begin tests_failed++; $display("FAIL both_din_held: got %h want a5a50040", mem_din); end
    mem_ren = 1'b0; mem_wen = 1'b0; bus_if.bus_ready = 1'b0;
    tick();
  endtask

`ifdef DMEM_TIMEOUT_EN
  task automatic test_timeout();
    int bad = 0;
    mem_ren = 1'b1; mem_addr = 32'h300; bus_if.bus_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (dbg_state !== BUSY || bus_err !== 1'b0) bad++;
      if (i < 3) tick();
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL timeout_busy: %0d bad BUSY cycles, want 0", bad); end
    tick();
    tests_run++;
    if (dbg_state !== DONE || mem_din !== 32'hDEAD_BEEF || bus_err !== 1'b1 || bus_if.bus_req !== 1'b0) begin
      tests_failed++; $display("FAIL timeout_abort: state=%0d din=%h err=%b req=%b want DONE deadbeef 1 0",
        dbg_state, mem_din, bus_err, bus_if.bus_req);
    end
    mem_ren = 1'b0;
    tick(); tick();
    tests_run++;
    if (bus_err !== 1'b1 || dbg_state !== IDLE) begin
      tests_failed++; $display("FAIL timeout_sticky: err=%b state=%0d want 1 IDLE", bus_err, dbg_state);
    end
  endtask
`else
  task automatic test_no_timeout();
    int bad = 0;
    mem_ren = 1'b1; mem_addr = 32'h200; bus_if.bus_ready = 1'b0; bus_if.bus_rdata = 32'h0F0F_0F0F;
    tick();
    for (int i = 0; i < 10; i++) begin
      if (dbg_state !== BUSY || bus_err !== 1'b0 || mem_stall !== 1'b1) bad++;
      tick();
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL no_timeout_wait: %0d bad BUSY cycles, want 0", bad); end
    bus_if.bus_ready = 1'b1;
    tick();
    tests_run++;
    if (dbg_state !== DONE || mem_din !== 32'h0F0F_0F0F || bus_err !== 1'b0) begin
      tests_failed++; $display("FAIL no_timeout_done: state=%0d din=%h err=%b want DONE 0f0f0f0f 0",
        dbg_state, mem_din, bus_err);
    end
    mem_ren = 1'b0; bus_if.bus_ready = 1'b0;
    tick();
  endtask
`endif

  task automatic test_reset_mid_busy();
    mem_ren = 1'b1; mem_addr = 32'h400; bus_if.bus_ready = 1'b0;
    tick();
    tests_run++;
    if (bus_if.bus_req !== 1'b1) begin tests_failed++; $display("FAIL rst_pre_req: got %b want 1", bus_if.bus_req); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus_if.bus_req !== 1'b0 || dbg_state !== IDLE) begin
      tests_failed++; $display("FAIL rst_async: req=%b state=%0d want 0 IDLE", bus_if.bus_req, dbg_state);
    end
    mem_ren = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    tests_run++;
    if (mem_din !== 32'h0 || dbg_state !== IDLE || bus_if.bus_req !== 1'b0) begin
      tests_failed++; $display("FAIL rst_release: din=%h state=%0d req=%b want 0 IDLE 0", mem_din, dbg_state, bus_if.bus_req);
    end
  endtask

  initial begin
    test_reset();
    test_spurious_ready();
    test_read_zero_wait();
    test_write_wait();
    test_back_to_back();
    test_ren_wen_both();
`ifdef DMEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
